// File: rtl/alu_pkg.sv
// Opcode encodings and controller state type shared by the ALU, the arbiter
// and the sharing controller.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SUB2 = 5'b00011;
    localparam logic [4:0] ALU_LSR  = 5'b00100;
    localparam logic [4:0] ALU_ASR  = 5'b00101;
    localparam logic [4:0] ALU_SL   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_NOT  = 5'b01001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_share_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU, 32-bit wrap-around arithmetic.
// The full 32-bit b is the shift amount, so shifts of 32 or more give 0 / sign fill.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    output logic [31:0] y
);

    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB, ALU_SUB2: y = a - b;
            ALU_LSR:           y = a >> b;
            ALU_ASR:           y = $unsigned($signed(a) >>> b);
            ALU_SL:            y = a << b;
            ALU_AND:           y = a & b;
            ALU_OR:            y = a | b;
            ALU_NOT:           y = ~a;
            default:           y = a + b;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping past NUM_REQ-1. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// registered operands, one evaluation cycle, registered tagged response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*5-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    alu_share_state_e state, state_nxt;

    logic [ID_W-1:0]    ptr;
    logic [31:0]        op_a, op_b;
    logic [4:0]         op_code;
    logic [ID_W-1:0]    op_id;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [31:0]        sel_a, sel_b, alu_y;
    logic [4:0]         sel_op;
    logic               take;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    ALU u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (op_code),
        .y  (alu_y)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*5 +: 5];
            end
        end
    end

    assign take = (state == IDLE) && gnt_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) ? gnt : '0;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Operands are frozen at grant so requester inputs cannot disturb EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= '0;
            op_id    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (take) begin
                op_a    <= sel_a;
                op_b    <= sel_b;
                op_code <= sel_op;
                op_id   <= gnt_idx;
                ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
            if (state == EXEC) begin
                rsp_data <= alu_y;
                rsp_id   <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model evaluated every cycle.
module tb_alu_share_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*5-1:0] req_op = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [31:0]    rsp_data;
    logic [1:0]     rsp_id;
    logic           busy;

    alu_share_ctrl #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd2, 5'd3: return a - b;
            5'd4:       return (b >= 32) ? 32'h0 : a >> b[4:0];
            5'd5:       return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
            5'd6:       return (b >= 32) ? 32'h0 : a << b[4:0];
            5'd7:       return a & b;
            5'd8:       return a | b;
            5'd9:       return ~a;
            default:    return a + b;
        endcase
    endfunction

    // Reference model: phase 0 = waiting for a grant, 1 = evaluating, 2 = response held.
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    int          m_pend_id = 0;
    int          m_last_g = -1;
    int          mg;
    logic [31:0] m_data = '0;
    logic [31:0] m_pend = '0;
    logic [N-1:0] m_er;
    int          cyc = 0;
    int          glog_idx[$];
    int          glog_cyc[$];

    always @(negedge clk) begin
        cyc++;
        m_last_g = -1;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            m_phase = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_id    = 0;
        end else begin
            m_er = '0;
            mg   = -1;
            if (m_phase == 0)
                for (int k = 0; k < N; k++)
                    if (mg < 0 && req_valid[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
            if (mg >= 0) m_er[mg] = 1'b1;
            chk("req_ready", req_ready, m_er);
            chk("busy", busy, m_phase != 0);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_id);
            case (m_phase)
                0: if (mg >= 0) begin
                    m_pend    = ref_alu(req_op[mg*5 +: 5], req_a[mg*32 +: 32], req_b[mg*32 +: 32]);
                    m_pend_id = mg;
                    m_ptr     = (mg + 1) % N;
                    m_last_g  = mg;
                    glog_idx.push_back(mg);
                    glog_cyc.push_back(cyc);
                    m_phase   = 1;
                end
                1: begin
                    m_data  = m_pend;
                    m_id    = m_pend_id;
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int r, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[r*5 +: 5]  = op;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_valid[r]      = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int r);
        int n = 0;
        while (!req_ready[r] && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, req_ready[r], 1);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 20) begin
            tick(1);
            n++;
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic run_op(input string tag, input int r, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        set_req(r, op, a, b);
        #1;
        wait_ready({tag, "_grant"}, r);
        tick(1);
        req_valid[r] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, "_latency"}, n + 1, 2);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_id"}, rsp_id, r);
        tick(1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int gl;
        logic [31:0] rb;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_reset_valid", rsp_valid, 0);
        chk("post_reset_data", rsp_data, 0);

        run_op("add", 0, 5'b00000, 32'd5, 32'd7, 32'd12);
        run_op("sub", 2, 5'b00010, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_op("asr", 2, 5'b00101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_op("lsr", 2, 5'b00100, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_op("sl", 2, 5'b00110, 32'd1, 32'd31, 32'h8000_0000);
        run_op("not", 2, 5'b01001, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run_op("undef_op", 2, 5'b11111, 32'd2, 32'd2, 32'd4);
        run_op("sub_alt", 1, 5'b00011, 32'd10, 32'd4, 32'd6);
        run_op("asr_big", 3, 5'b00101, 32'h8000_0001, 32'd40, 32'hFFFF_FFFF);
        run_op("lsr_big", 3, 5'b00100, 32'hFFFF_FFFF, 32'd32, 32'h0);

        // Fairness: all requesters valid from reset
        do_reset();
        glog_idx.delete();
        glog_cyc.delete();
        for (int i = 0; i < N; i++) set_req(i, 5'b00000, 32'(i), 32'd100);
        tick(16);
        req_valid = '0;
        drain();
        chk("rr_count", glog_idx.size() >= 5, 1);
        if (glog_idx.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr_order_%0d", k), glog_idx[k], k % N);
                if (k > 0) chk($sformatf("rr_gap_%0d", k), glog_cyc[k] - glog_cyc[k-1], 3);
            end

        // Backpressure
        rsp_ready = 1'b0;
        set_req(1, 5'b00000, 32'd1, 32'd2);
        #1;
        wait_ready("bp_grant", 1);
        tick(1);
        req_valid[1] = 1'b0;
        set_req(2, 5'b00111, 32'hF0F0, 32'hFF00);
        tick(1);
        gl = glog_idx.size();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 32'd3);
            chk("bp_id", rsp_id, 1);
            chk("bp_no_ready", req_ready, 0);
            tick(1);
        end
        chk("bp_no_grant", glog_idx.size(), gl);
        rsp_ready = 1'b1;
        tick(1);
        chk("bp_next_grant", req_ready, 4'b0100);
        tick(1);
        req_valid[2] = 1'b0;
        drain();

        // Reset during EXEC, then check the pointer returned to 0
        set_req(1, 5'b00000, 32'd8, 32'd8);
        #1;
        wait_ready("rx_grant", 1);
        tick(1);
        req_valid[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rx_busy", busy, 0);
        chk("rx_valid", rsp_valid, 0);
        chk("rx_ready", req_ready, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        set_req(3, 5'b00000, 32'd0, 32'd0);
        set_req(0, 5'b00000, 32'd0, 32'd0);
        #1;
        chk("rx_ptr_zero", req_ready, 4'b0001);
        tick(1);
        req_valid = '0;
        drain();

        // Reset during RESP
        set_req(1, 5'b00010, 32'd9, 32'd2);
        #1;
        wait_ready("rr_grant", 1);
        tick(1);
        req_valid[1] = 1'b0;
        rsp_ready = 1'b0;
        tick(1);
        chk("rr_pre_data", rsp_data, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_data", rsp_data, 0);
        chk("rr_id", rsp_id, 0);
        chk("rr_valid", rsp_valid, 0);
        tick(1);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        tick(1);
        run_op("after_rst", 1, 5'b01000, 32'h00F0, 32'h0F00, 32'h0FF0);

        // Late/dropped requests while requester 1 is in service
        glog_idx.delete();
        glog_cyc.delete();
        set_req(1, 5'b00000, 32'd1, 32'd1);
        #1;
        wait_ready("tg_grant", 1);
        tick(1);
        req_valid[1] = 1'b0;
        set_req(3, 5'b00000, 32'd3, 32'd3);
        set_req(2, 5'b00000, 32'd2, 32'd2);
        tick(1);
        rsp_ready = 1'b0;
        req_valid[3] = 1'b0;
        tick(1);
        req_valid[3] = 1'b1;
        req_valid[2] = 1'b0;
        tick(1);
        rsp_ready = 1'b1;
        tick(1);
        chk("tg_ready3", req_ready, 4'b1000);
        tick(1);
        req_valid[3] = 1'b0;
        drain();
        chk("tg_count", glog_idx.size(), 2);
        if (glog_idx.size() == 2) begin
            chk("tg_first", glog_idx[0], 1);
            chk("tg_second", glog_idx[1], 3);
        end

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (m_last_g >= 0) req_valid[m_last_g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 4 == 0)) begin
                    rb = ($urandom % 2) ? $urandom_range(0, 40) : $urandom;
                    set_req(i, ($urandom % 2) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 31)),
                            $urandom, rb);
                end else if (req_valid[i] && ($urandom % 32 == 0)) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom % 3 != 0);
            tick(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
